// File: rtl/gamma_lut_loader_pkg.sv
// rtl/gamma_lut_loader_pkg.sv - shared state encoding and plane-select constants for the gamma LUT loader
package gamma_lut_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] CP_BCAST = 2'd3;

endpackage

// File: rtl/gamma_lut_loader.sv
// rtl/gamma_lut_loader.sv - fills one or all gamma LUT planes from a host stream or an identity ramp
module gamma_lut_loader
   import gamma_lut_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUMCP      = 3
) (
   input  logic                  clk,
   input  logic                  sr,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            cp_sel,
   input  logic                  ramp,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  lut0wren,
   output logic [DATA_WIDTH-1:0] lut0val,
   output logic                  lut1wren,
   output logic [DATA_WIDTH-1:0] lut1val,
   output logic                  lut2wren,
   output logic [DATA_WIDTH-1:0] lut2val,
   output logic                  gc_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CW = DATA_WIDTH + 1;
   localparam logic [CW-1:0] LAST = CW'((1 << DATA_WIDTH) - 1);

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [1:0]              cp_q, cp_d;
   logic                    ramp_q, ramp_d;
   logic                    err_q, err_d;
   logic                    gc_hold_q, gc_hold_d;
   logic                    accept;
   logic                    cp_legal;
   logic [DATA_WIDTH-1:0]   value;
   logic [2:0]              wren_all;
   logic [DATA_WIDTH-1:0]   val_all [3];

   assign cp_legal = (32'(cp_sel) < NUMCP) || (cp_sel == CP_BCAST);
   assign wr_ready = (state_q == ST_LOAD) && !ramp_q;
   assign accept   = (state_q == ST_LOAD) && (ramp_q || wr_valid);
   assign value    = ramp_q ? cnt_q[DATA_WIDTH-1:0] : wr_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cp_d    = cp_q;
      ramp_d  = ramp_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // abort beats a simultaneous start, and suppresses the err pulse too
            if (start && !abort) begin
               if (cp_legal) begin
                  state_d = ST_LOAD;
                  cnt_d   = '0;
                  cp_d    = cp_sel;
                  ramp_d  = ramp;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            err_d = start;
            if (accept) cnt_d = cnt_q + CW'(1);
            if (abort) state_d = ST_IDLE;
            else if (accept && (cnt_q == LAST)) state_d = ST_DONE;
         end
         ST_DONE: begin
            err_d   = start;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // also covers the cycle after an abort, when the final accepted entry is still being written
      gc_hold_d = (state_d != ST_IDLE) || (state_q == ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (sr) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         cp_q      <= '0;
         ramp_q    <= 1'b0;
         err_q     <= 1'b0;
         gc_hold_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cp_q      <= cp_d;
         ramp_q    <= ramp_d;
         err_q     <= err_d;
         gc_hold_q <= gc_hold_d;
      end
   end

   for (genvar p = 0; p < 3; p++) begin : g_plane
      if (p < NUMCP) begin : g_on
         logic                  wren_q;
         logic [DATA_WIDTH-1:0] val_q;
         logic                  sel;
         assign sel = accept && ((cp_q == 2'(p)) || (cp_q == CP_BCAST));
         always_ff @(posedge clk) begin
            if (sr) begin
               wren_q <= 1'b0;
               val_q  <= '0;
            end else begin
               wren_q <= sel;
               if (sel) val_q <= value;
            end
         end
         assign wren_all[p] = wren_q;
         assign val_all[p]  = val_q;
      end else begin : g_off
         assign wren_all[p] = 1'b0;
         assign val_all[p]  = '0;
      end
   end

   assign lut0wren = wren_all[0];
   assign lut0val  = val_all[0];
   assign lut1wren = wren_all[1];
   assign lut1val  = val_all[1];
   assign lut2wren = wren_all[2];
   assign lut2val  = val_all[2];
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign err      = err_q;
   assign gc_hold  = gc_hold_q;

endmodule

// File: tb/tb_gamma_lut_loader.sv
// tb/tb_gamma_lut_loader.sv - directed self-checking bench for gamma_lut_loader at DATA_WIDTH=4
module tb_gamma_lut_loader;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          sr = 1'b1;
   logic          start = 1'b0, start2 = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    cp_sel = 2'd0;
   logic          ramp = 1'b0;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0;

   logic          wr_ready, lut0wren, lut1wren, lut2wren, gc_hold, busy, done, err;
   logic [DW-1:0] lut0val, lut1val, lut2val;
   logic          d2_wr_ready, d2_lut0wren, d2_lut1wren, d2_lut2wren, d2_gc_hold, d2_busy, d2_done, d2_err;
   logic [DW-1:0] d2_lut0val, d2_lut1val, d2_lut2val;

   int checks = 0;
   int errors = 0;
   int nwr;

   gamma_lut_loader #(.DATA_WIDTH(DW), .NUMCP(3)) dut (
      .clk(clk), .sr(sr), .start(start), .abort(abort), .cp_sel(cp_sel), .ramp(ramp),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .lut0wren(lut0wren), .lut0val(lut0val), .lut1wren(lut1wren), .lut1val(lut1val),
      .lut2wren(lut2wren), .lut2val(lut2val),
      .gc_hold(gc_hold), .busy(busy), .done(done), .err(err)
   );

   gamma_lut_loader #(.DATA_WIDTH(DW), .NUMCP(2)) dut2 (
      .clk(clk), .sr(sr), .start(start2), .abort(abort), .cp_sel(cp_sel), .ramp(ramp),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(d2_wr_ready),
      .lut0wren(d2_lut0wren), .lut0val(d2_lut0val), .lut1wren(d2_lut1wren), .lut1val(d2_lut1val),
      .lut2wren(d2_lut2wren), .lut2val(d2_lut2val),
      .gc_hold(d2_gc_hold), .busy(d2_busy), .done(d2_done), .err(d2_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_gc_hold", 32'(gc_hold), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_wrens", {29'd0, lut2wren, lut1wren, lut0wren}, 0);
      chk("rst_vals", {20'd0, lut2val, lut1val, lut0val}, 0);
      sr = 1'b0;
      tick();

      // host mode, plane 1, data 15-k
      start = 1'b1; cp_sel = 2'd1; ramp = 1'b0; wr_valid = 1'b1; wr_data = 4'd15;
      tick();
      start = 1'b0;
      chk("h_busy", 32'(busy), 1);
      chk("h_gc_hold", 32'(gc_hold), 1);
      for (int k = 0; k < 16; k++) begin
         wr_data = 4'(15 - k);
         chk("h_wr_ready", 32'(wr_ready), 1);
         tick();
         chk("h_lut1wren", 32'(lut1wren), 1);
         chk("h_lut1val", 32'(lut1val), 32'(15 - k));
         chk("h_other_wren", {30'd0, lut2wren, lut0wren}, 0);
         chk("h_done", 32'(done), (k == 15) ? 1 : 0);
      end
      chk("h_ready_in_done", 32'(wr_ready), 0);
      wr_valid = 1'b0;
      tick();
      chk("h_end_done", 32'(done), 0);
      chk("h_end_busy", 32'(busy), 0);
      chk("h_end_gc_hold", 32'(gc_hold), 0);
      chk("h_end_wren", 32'(lut1wren), 0);
      chk("h_hold_val", 32'(lut1val), 0);

      // ramp mode, broadcast; host stream must be ignored
      start = 1'b1; cp_sel = 2'd3; ramp = 1'b1; wr_valid = 1'b1; wr_data = 4'hA;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("r_wr_ready", 32'(wr_ready), 0);
         chk("r_gc_hold", 32'(gc_hold), 1);
         tick();
         chk("r_wrens", {29'd0, lut2wren, lut1wren, lut0wren}, 7);
         chk("r_vals", {20'd0, lut2val, lut1val, lut0val}, {20'd0, 4'(k), 4'(k), 4'(k)});
         chk("r_done", 32'(done), (k == 15) ? 1 : 0);
      end
      wr_valid = 1'b0;
      tick();
      chk("r_end_gc_hold", 32'(gc_hold), 0);
      chk("r_end_wrens", {29'd0, lut2wren, lut1wren, lut0wren}, 0);
      chk("r_hold_vals", {20'd0, lut2val, lut1val, lut0val}, 32'hFFF);

      // host mode with wr_valid toggling
      start = 1'b1; cp_sel = 2'd0; ramp = 1'b0;
      tick();
      start = 1'b0;
      nwr = 0;
      for (int c = 0; c < 32; c++) begin
         wr_valid = (c % 2 == 0);
         wr_data  = 4'(c / 2);
         tick();
         if (lut0wren) nwr++;
         chk("t_wren", 32'(lut0wren), (c % 2 == 0) ? 1 : 0);
         if (c % 2 == 0) chk("t_val", 32'(lut0val), 32'(c / 2));
         chk("t_done", 32'(done), (c == 30) ? 1 : 0);
      end
      chk("t_count", 32'(nwr), 16);
      wr_valid = 1'b0;
      tick();

      // abort after 5 writes, then a fresh load
      start = 1'b1; cp_sel = 2'd2; ramp = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wr_valid = 1'b1; wr_data = 4'(k + 1);
         abort = (k == 4);
         tick();
         chk("a_wren", 32'(lut2wren), 1);
         chk("a_val", 32'(lut2val), 32'(k + 1));
      end
      abort = 1'b0; wr_valid = 1'b0;
      chk("a_busy_after", 32'(busy), 0);
      chk("a_done_after", 32'(done), 0);
      chk("a_gc_after", 32'(gc_hold), 1);
      tick();
      chk("a_wren_gap", 32'(lut2wren), 0);
      chk("a_gc_gone", 32'(gc_hold), 0);
      chk("a_done_gap", 32'(done), 0);
      start = 1'b1; ramp = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         chk("a2_wren", 32'(lut2wren), 1);
         chk("a2_val", 32'(lut2val), 32'(k));
         chk("a2_done", 32'(done), (k == 15) ? 1 : 0);
      end
      tick();

      // start and abort together in IDLE: nothing happens
      start = 1'b1; abort = 1'b1; cp_sel = 2'd0;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", 32'(busy), 0);
      chk("sa_err", 32'(err), 0);
      tick();
      chk("sa_wren", 32'(lut0wren), 0);

      // illegal plane on a two-plane loader
      start2 = 1'b1; cp_sel = 2'd2; ramp = 1'b0;
      tick();
      start2 = 1'b0;
      chk("il_err", 32'(d2_err), 1);
      chk("il_busy", 32'(d2_busy), 0);
      tick();
      chk("il_err_gone", 32'(d2_err), 0);
      chk("il_wrens", {29'd0, d2_lut2wren, d2_lut1wren, d2_lut0wren}, 0);
      chk("il_busy2", 32'(d2_busy), 0);

      // start during LOAD is rejected and the load completes
      start = 1'b1; cp_sel = 2'd0; ramp = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) begin
         start  = (k == 3);
         cp_sel = (k == 3) ? 2'd1 : 2'd0;
         ramp   = (k != 3);
         tick();
         chk("sl_wren", 32'(lut0wren), 1);
         chk("sl_val", 32'(lut0val), 32'(k));
         chk("sl_lut1", 32'(lut1wren), 0);
         chk("sl_err", 32'(err), (k == 3) ? 1 : 0);
         chk("sl_done", 32'(done), (k == 15) ? 1 : 0);
      end
      start = 1'b0;
      tick();

      // synchronous reset mid-load
      start = 1'b1; cp_sel = 2'd3; ramp = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("sr_pre_wren", {29'd0, lut2wren, lut1wren, lut0wren}, 7);
      sr = 1'b1;
      tick();
      sr = 1'b0;
      chk("sr_wrens", {29'd0, lut2wren, lut1wren, lut0wren}, 0);
      chk("sr_vals", {20'd0, lut2val, lut1val, lut0val}, 0);
      chk("sr_flags", {27'd0, busy, done, err, gc_hold, wr_ready}, 0);
      nwr = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (done || lut0wren || lut1wren || lut2wren) nwr++;
      end
      chk("sr_quiet", 32'(nwr), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
